mem_write_buffer: RTL and testbench

Write-through store buffer between the MEM-stage data cache and the unified 4-cycle main memory. Queues each store as an {address, data} pair and drains one entry per cycle to memory while the cache fill FSM is idle. Gives block refills priority unless a queued store targets the block being refilled; in that case it drains first so the refill never returns stale data. Asserts `wb_full` as a MEM-stage stall source, alongside the D-cache miss stall.

---
 rtl/mem_write_buffer.sv | 118 +++++++++++
 tb/tb_mem_write_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Write-through store buffer: queues MEM-stage stores and drains one per cycle to main memory,
// yielding to cache refills unless a queued store hits the refill block. Option: WBUF_COALESCE_EN.
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wb_full,
    output logic        wb_empty,
    input  logic        fill_req,
    input  logic [15:0] fill_addr,
    input  logic        fill_busy,
    output logic        fill_grant,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data
);
    typedef enum logic [1:0] {IDLE, DRAIN, YIELD} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][15:0] addr_q;
    logic [DEPTH-1:0][15:0] data_q;
    logic [DEPTH-1:0]       valid_q;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         count;
    logic [PTR_W:0]         count_next;
    state_t                 state;

    logic conflict_hit;
    logic conflict;
    logic pop;
    logic merge;
    logic alloc;

    assign wb_full  = (count == FULL_CNT);
    assign wb_empty = (count == '0);

    // A refill must not overtake a store to the same 16-byte block.
    always_comb begin
        conflict_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i] && addr_q[i][15:4] == fill_addr[15:4])
                conflict_hit = 1'b1;
    end

    assign conflict   = fill_req & conflict_hit;
    assign fill_grant = fill_req & ~fill_busy & ~conflict;
    assign pop        = ~rst & (count != '0) & ~fill_busy & ~fill_grant;

    assign mem_en   = pop;
    assign mem_wr   = pop;
    assign mem_addr = pop ? addr_q[head] : 16'h0000;
    assign mem_data = pop ? data_q[head] : 16'h0000;

`ifdef WBUF_COALESCE_EN
    logic             merge_hit;
    logic [PTR_W-1:0] merge_idx;

    // The head is excluded so a drain presented this cycle is never altered.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (!merge_hit && valid_q[i] && PTR_W'(i) != head && addr_q[i] == wr_addr) begin
                merge_hit = 1'b1;
                merge_idx = PTR_W'(i);
            end
    end
    assign merge = wr_req & merge_hit;
`else
    assign merge = 1'b0;
`endif

    assign alloc      = wr_req & ~wb_full & ~merge;
    assign count_next = count + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
            state   <= IDLE;
        end else begin
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (alloc) begin
                addr_q[tail]  <= wr_addr;
                data_q[tail]  <= wr_data;
                valid_q[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
`ifdef WBUF_COALESCE_EN
            if (merge)
                data_q[merge_idx] <= wr_data;
`endif
            count <= count_next;

            case (state)
                IDLE:    if (alloc) state <= DRAIN;
                DRAIN:   if (fill_grant || fill_busy) state <= YIELD;
                         else if (count_next == '0) state <= IDLE;
                YIELD:   if (!fill_busy && !fill_grant)
                             state <= (count_next != '0) ? DRAIN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: a queue-level model predicts each cycle's drains and
// status outputs; a separate monitor pops expected drains whenever mem_en is seen.
module tb_mem_write_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, wr_req, fill_req, fill_busy;
    logic [15:0] wr_addr, wr_data, fill_addr;
    logic        wb_full, wb_empty, fill_grant, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data;

    mem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_full(wb_full), .wb_empty(wb_empty), .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_busy(fill_busy), .fill_grant(fill_grant), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t mq[$];   // buffer contents as the model sees them, oldest first
    ent_t sb[$];   // drains expected, in order
    int   checks = 0;
    int   fails  = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, check at negedge, then advance the model at the edge.
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic fr, input logic [15:0] fa, input logic fb);
        int   n;
        bit   cf, e_grant, e_drain, merged, accept;
        ent_t e;
        rst = r; wr_req = w; wr_addr = a; wr_data = d;
        fill_req = fr; fill_addr = fa; fill_busy = fb;
        n  = mq.size();
        cf = 1'b0;
        foreach (mq[i]) if (mq[i].a[15:4] == fa[15:4]) cf = 1'b1;
        e_grant = fr && !fb && !cf;
        e_drain = !r && n > 0 && !fb && !e_grant;
        if (e_drain) sb.push_back(mq[0]);
        @(negedge clk);
        chk("wb_full", wb_full, n == DEPTH);
        chk("wb_empty", wb_empty, n == 0);
        chk("fill_grant", fill_grant, e_grant);
        chk("mem_en", mem_en, e_drain);
        chk("mem_wr", mem_wr, e_drain);
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            merged = 1'b0;
`ifdef WBUF_COALESCE_EN
            if (w)
                for (int i = 1; i < n; i++)
                    if (!merged && mq[i].a == a) begin
                        mq[i].d = d;
                        merged  = 1'b1;
                    end
`endif
            accept = w && !merged && n < DEPTH;
            if (e_drain) void'(mq.pop_front());
            if (accept) begin
                e.a = a; e.d = d;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int cycles, input logic fb);
        for (int i = 0; i < cycles; i++) step(0, 0, 16'h0, 16'h0, 0, 16'h0, fb);
    endtask

    // Monitor: every drain must match the oldest expected entry; idle buses must be zero.
    initial begin
        ent_t ex;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (mem_en === 1'b1) begin
                    if (sb.size() == 0) chk("unexpected_drain", 32'd1, 32'd0);
                    else begin
                        ex = sb.pop_front();
                        chk("mem_addr", mem_addr, ex.a);
                        chk("mem_data", mem_data, ex.d);
                    end
                end else begin
                    chk("idle_mem_addr", mem_addr, 32'd0);
                    chk("idle_mem_data", mem_data, 32'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; wr_req = 0; wr_addr = 0; wr_data = 0;
        fill_req = 0; fill_addr = 0; fill_busy = 0;
        @(posedge clk); #1;
        mon_on = 1'b1;
        step(1, 0, 16'h0, 16'h0, 0, 16'h0, 0);
        idle(1, 0);

        // Single store drains the cycle after the push.
        step(0, 1, 16'h0010, 16'hAAAA, 0, 16'h0, 0);
        idle(2, 0);

        // Fill to full under fill_busy, fifth store refused, then back-to-back drains.
        for (int i = 0; i < 5; i++) step(0, 1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 0, 16'h0, 1);
        idle(5, 0);

        // Conflicting refill waits for the matching store to drain.
        step(0, 1, 16'h0024, 16'h2424, 0, 16'h0, 1);
        step(0, 0, 16'h0, 16'h0, 1, 16'h0020, 0);
        step(0, 0, 16'h0, 16'h0, 1, 16'h0020, 0);
        idle(2, 1);
        idle(1, 0);

        // Non-conflicting refill wins immediately; store waits out fill_busy.
        step(0, 1, 16'h0100, 16'h0B0B, 0, 16'h0, 1);
        step(0, 0, 16'h0, 16'h0, 1, 16'h0200, 0);
        idle(3, 1);
        idle(2, 0);

        // Same-address stores (coalesce when enabled).
        step(0, 1, 16'h0030, 16'h0001, 0, 16'h0, 1);
        step(0, 1, 16'h0040, 16'h0002, 0, 16'h0, 1);
        step(0, 1, 16'h0040, 16'h0003, 0, 16'h0, 1);
        idle(4, 0);

        // Reset with three entries queued discards them.
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0500 + 16'(i), 16'h5500 + 16'(i), 0, 16'h0, 1);
        step(1, 0, 16'h0, 16'h0, 0, 16'h0, 0);
        idle(2, 0);

        // Random traffic over a few blocks so conflicts, wraps and coalescing occur.
        for (int i = 0; i < 2000; i++) begin
            logic        r, w, fr, fb;
            logic [15:0] a, d, fa;
            r  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 1) == 1);
            a  = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 1));
            d  = 16'($urandom());
            fr = ($urandom_range(0, 9) < 3);
            fa = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            fb = ($urandom_range(0, 3) == 0);
            step(r, w, a, d, fr, fa, fb);
        end

        idle(DEPTH + 4, 0);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("model_empty", mq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
